// File: rtl/claa_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder: one 4-bit carry look-ahead step per clock, LSB nibble first.
// Optional registered signed-overflow output ovf when CLAA_SERIAL_OVF_EN is defined.
//   state   | meaning
//   IDLE    | waiting for start; s/cout hold last result
//   RUN     | one nibble added per edge, carry chained through carry_q
//   DONE    | one-cycle done pulse; start ignored
module claa_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef CLAA_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N    = WIDTH / 4;
    localparam int IDXW = $clog2(N);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry_q;
    logic [IDXW-1:0]  idx;
    logic             last;

    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] sum_nib;

    always_comb begin
        a_nib = 4'(a_q >> {idx, 2'b00});
        b_nib = 4'(b_q >> {idx, 2'b00});
        g     = a_nib & b_nib;
        p     = a_nib ^ b_nib;
        c[0]  = carry_q;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum_nib = p ^ c[3:0];
        last    = (idx == IDXW'(N - 1));
    end

    // Merge this step's nibble so the completion edge can publish the whole word at once.
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < N; i++) begin
            if (idx == IDXW'(i)) acc_next[i*4 +: 4] = sum_nib;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            cout    <= 1'b0;
`ifdef CLAA_SERIAL_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc     <= acc_next;
                    carry_q <= c[4];
                    idx     <= idx + IDXW'(1);
                    if (last) begin
                        s     <= acc_next;
                        cout  <= c[4];
`ifdef CLAA_SERIAL_OVF_EN
                        ovf   <= c[3] ^ c[4];
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
